ball_renderer: RTL

Consumer end of the ball-position path: accepts each new ball position produced by the movement logic and turns it into a pixel-write stream for the VGA adapter. For every accepted position it first erases the square sprite at the previously drawn position with the background colour, then draws it at the new position, one pixel per clock. The block sits between the ball-movement logic and the VGA adapter's plot port.

---
 rtl/ball_render_pkg.sv | 35 +++
 rtl/sprite_scanner.sv | 58 +++++
 rtl/ball_renderer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ball_render_pkg.sv
// ball_render_pkg: shared types and constants for the ball renderer.
//   state_e     : renderer FSM states (IDLE / ERASE / DRAW / DONE)
//   COLOUR_W    : VGA colour width (3)
//   COORD_W     : screen coordinate width (10)
//   SUM_W       : width of coordinate + offset sums (11), one bit of headroom
//   SCAN_W      : width of the sprite scan offsets (4, sprites up to 16x16)
//   defaults    : screen size and colour defaults for ball_renderer
//   is_corner() : true when a scan offset pair sits on a corner of the square
package ball_render_pkg;

  localparam int COLOUR_W = 3;
  localparam int COORD_W  = 10;
  localparam int SUM_W    = 11;
  localparam int SCAN_W   = 4;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  localparam logic [COLOUR_W-1:0] BG_COLOUR_DEFAULT   = 3'b000;
  localparam logic [COLOUR_W-1:0] BALL_COLOUR_DEFAULT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_corner(input logic [SCAN_W-1:0] dx,
                                     input logic [SCAN_W-1:0] dy,
                                     input logic [SCAN_W-1:0] last_idx);
    return ((dx == '0) || (dx == last_idx)) && ((dy == '0) || (dy == last_idx));
  endfunction

endpackage

// File: rtl/sprite_scanner.sv
// sprite_scanner: row-major offset generator for a BALL_SIZE x BALL_SIZE sprite.
// One instance is shared by the erase and draw phases of ball_renderer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : load dx = dy = 0 (takes priority over advance)
//   advance    : step to the next offset, dx fastest, wrapping after the last
//   dx, dy     : current offset within the sprite
//   last       : current offset is the final one (dx = dy = BALL_SIZE-1)
module sprite_scanner
  import ball_render_pkg::*;
#(
  parameter int BALL_SIZE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  output logic [SCAN_W-1:0] dx,
  output logic [SCAN_W-1:0] dy,
  output logic              last
);

  localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(BALL_SIZE - 1);

  logic [SCAN_W-1:0] dx_q, dx_d;
  logic [SCAN_W-1:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (start) begin
      dx_d = '0;
      dy_d = '0;
    end else if (advance) begin
      if (dx_q == LAST_IDX) begin
        dx_d = '0;
        dy_d = (dy_q == LAST_IDX) ? '0 : dy_q + 4'd1;
      end else begin
        dx_d = dx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == LAST_IDX) && (dy_q == LAST_IDX);

endmodule

// File: rtl/ball_renderer.sv
// ball_renderer: turns accepted ball positions into a VGA pixel-write stream.
// For each accepted position the sprite at the previously drawn position is
// erased with BG_COLOUR, then redrawn at the new position with BALL_COLOUR,
// one pixel per clock. Pixels off the right/bottom edge are clipped (not
// plotted) but still take their cycle.
// Optional feature macro: BALL_RENDER_ROUND_EN -- when defined, the four
// corner pixels of the square are never plotted (sprites of 3x3 or larger).
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   pos_valid/pos_ready  : position handshake (see below)
//   ball_x, ball_y       : top-left corner of the new sprite position
//   vga_x, vga_y         : pixel coordinate (registered)
//   vga_colour           : pixel colour (registered)
//   vga_plot             : write enable for the pixel on vga_x/vga_y/vga_colour
//   done                 : one-cycle pulse after a full erase+draw
// Handshake: a position transfers on a rising edge where pos_valid and
// pos_ready are both high; the source holds ball_x/ball_y stable until then.
// pos_ready drops the cycle after a transfer and stays low until the renderer
// has returned to IDLE, so pos_valid while busy has no effect.
module ball_renderer
  import ball_render_pkg::*;
#(
  parameter int                   BALL_SIZE   = 4,
  parameter int                   SCREEN_W    = SCREEN_W_DEFAULT,
  parameter int                   SCREEN_H    = SCREEN_H_DEFAULT,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR   = BG_COLOUR_DEFAULT,
  parameter logic [COLOUR_W-1:0]  BALL_COLOUR = BALL_COLOUR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pos_valid,
  output logic                pos_ready,
  input  logic [COORD_W-1:0]  ball_x,
  input  logic [COORD_W-1:0]  ball_y,
  output logic [COORD_W-1:0]  vga_x,
  output logic [COORD_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                done
);

  localparam logic [SUM_W-1:0] X_LIMIT = SUM_W'(SCREEN_W);
  localparam logic [SUM_W-1:0] Y_LIMIT = SUM_W'(SCREEN_H);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   new_x_q, new_x_d;
  logic [COORD_W-1:0]   new_y_q, new_y_d;
  logic [COORD_W-1:0]   old_x_q, old_x_d;
  logic [COORD_W-1:0]   old_y_q, old_y_d;
  logic                 drawn_q, drawn_d;
  logic                 pos_ready_q, pos_ready_d;
  logic [COORD_W-1:0]   vga_x_q, vga_x_d;
  logic [COORD_W-1:0]   vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]  vga_colour_q, vga_colour_d;
  logic                 vga_plot_q, vga_plot_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 scan_start;
  logic                 scan_adv;
  logic [SCAN_W-1:0]    scan_dx;
  logic [SCAN_W-1:0]    scan_dy;
  logic                 scan_last;

  logic                 in_scan;
  logic [COORD_W-1:0]   base_x;
  logic [COORD_W-1:0]   base_y;
  logic [SUM_W-1:0]     sum_x;
  logic [SUM_W-1:0]     sum_y;
  logic                 corner;

  sprite_scanner #(
    .BALL_SIZE (BALL_SIZE)
  ) u_scanner (
    .clk     (clk),
    .reset   (reset),
    .start   (scan_start),
    .advance (scan_adv),
    .dx      (scan_dx),
    .dy      (scan_dy),
    .last    (scan_last)
  );

  // FSM and position bookkeeping
  always_comb begin
    state_d    = state_q;
    new_x_d    = new_x_q;
    new_y_d    = new_y_q;
    old_x_d    = old_x_q;
    old_y_d    = old_y_q;
    drawn_d    = drawn_q;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    accept     = (state_q == ST_IDLE) && pos_valid && pos_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          new_x_d    = ball_x;
          new_y_d    = ball_y;
          scan_start = 1'b1;
          // Nothing on screen yet after reset, so there is nothing to erase.
          state_d    = drawn_q ? ST_ERASE : ST_DRAW;
        end
      end
      ST_ERASE: begin
        scan_adv = 1'b1;
        if (scan_last) begin
          scan_start = 1'b1;
          state_d    = ST_DRAW;
        end
      end
      ST_DRAW: begin
        scan_adv = 1'b1;
        if (scan_last) begin
          old_x_d = new_x_q;
          old_y_d = new_y_q;
          drawn_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pixel generation. Outputs are registered one cycle behind the FSM state,
  // so the externally visible handshake flags are derived from state_q too.
  always_comb begin
    in_scan = (state_q == ST_ERASE) || (state_q == ST_DRAW);
    base_x  = (state_q == ST_ERASE) ? old_x_q : new_x_q;
    base_y  = (state_q == ST_ERASE) ? old_y_q : new_y_q;
    // 11-bit sums so positions near 1023 do not wrap back onto the screen.
    sum_x   = {1'b0, base_x} + {7'b0, scan_dx};
    sum_y   = {1'b0, base_y} + {7'b0, scan_dy};

`ifdef BALL_RENDER_ROUND_EN
    corner  = (BALL_SIZE >= 3) &&
              is_corner(scan_dx, scan_dy, SCAN_W'(BALL_SIZE - 1));
`else
    corner  = 1'b0;
`endif

    vga_plot_d   = in_scan && (sum_x < X_LIMIT) && (sum_y < Y_LIMIT) && !corner;
    vga_x_d      = in_scan ? sum_x[COORD_W-1:0] : vga_x_q;
    vga_y_d      = in_scan ? sum_y[COORD_W-1:0] : vga_y_q;
    vga_colour_d = vga_colour_q;
    if (state_q == ST_ERASE) begin
      vga_colour_d = BG_COLOUR;
    end else if (state_q == ST_DRAW) begin
      vga_colour_d = BALL_COLOUR;
    end

    // Drop ready immediately on the accepting edge so the source never sees
    // ready while the position is being rendered.
    pos_ready_d = (state_q == ST_IDLE) && !accept;
    done_d      = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      new_x_q      <= '0;
      new_y_q      <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      drawn_q      <= 1'b0;
      pos_ready_q  <= 1'b1;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      drawn_q      <= drawn_d;
      pos_ready_q  <= pos_ready_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
    end
  end

  assign pos_ready  = pos_ready_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign done       = done_q;

endmodule
